// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage MIPS-style pipeline: load-use/branch/mul-div stalls,
// jump flush, ID- and EX-stage forwarding selects, and the multicycle-unit occupancy FSM.
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] id_waddr,
    input  logic       id_write,
    input  logic       id_load,
    input  logic       id_branch,
    input  logic       id_jump,
    input  logic       id_md_start,
    input  logic       id_use_md,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic [1:0] id_fwd_a,
    output logic [1:0] id_fwd_b,
    output logic [1:0] ex_fwd_a,
    output logic [1:0] ex_fwd_b,
    output logic       md_busy
);

    typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;

    localparam logic [4:0] LP_MD_LOAD = 5'(MD_LAT - 1);

    logic       r_ex_v, r_ex_ld, r_ex_use_rs, r_ex_use_rt;
    logic [4:0] r_ex_wa, r_ex_rs, r_ex_rt;
    logic       r_mem_v, r_mem_ld;
    logic [4:0] r_mem_wa;
    logic       r_wb_v;
    logic [4:0] r_wb_wa;

    md_state_t  r_md_state, w_md_state_nxt;
    logic [4:0] r_md_cnt, w_md_cnt_nxt;

    logic w_id_v, w_use_a_ex, w_use_b_ex, w_use_a_mem_ld, w_use_b_mem_ld;
    logic w_load_use, w_branch_stall, w_md_stall, w_stall;

    // Register 0 is hard-wired, so a zero source never matches a producer.
    function automatic logic f_hit(input logic v, input logic [4:0] wa, input logic [4:0] src);
        return v && (wa == src) && (src != 5'd0);
    endfunction

    function automatic logic [1:0] f_fwd(input logic [4:0] src);
        if (f_hit(r_mem_v && !r_mem_ld, r_mem_wa, src))
            return 2'b01;
        else if (f_hit(r_wb_v, r_wb_wa, src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign w_id_v         = id_write && (id_waddr != 5'd0);
    assign w_use_a_ex     = id_use_rs && f_hit(r_ex_v, r_ex_wa, id_rs);
    assign w_use_b_ex     = id_use_rt && f_hit(r_ex_v, r_ex_wa, id_rt);
    assign w_use_a_mem_ld = id_use_rs && f_hit(r_mem_v && r_mem_ld, r_mem_wa, id_rs);
    assign w_use_b_mem_ld = id_use_rt && f_hit(r_mem_v && r_mem_ld, r_mem_wa, id_rt);

    assign w_load_use     = r_ex_ld && (w_use_a_ex || w_use_b_ex);
    assign w_branch_stall = id_branch && (w_use_a_ex || w_use_b_ex || w_use_a_mem_ld || w_use_b_mem_ld);
    assign w_md_stall     = md_busy && (id_use_md || id_md_start);
    assign w_stall        = w_load_use || w_branch_stall || w_md_stall;

    assign pc_en       = !w_stall;
    assign ifid_en     = !w_stall;
    assign idex_bubble = w_stall;
    assign ifid_flush  = id_jump && !w_stall;

    assign id_fwd_a = f_fwd(id_rs);
    assign id_fwd_b = f_fwd(id_rt);
    assign ex_fwd_a = r_ex_use_rs ? f_fwd(r_ex_rs) : 2'b00;
    assign ex_fwd_b = r_ex_use_rt ? f_fwd(r_ex_rt) : 2'b00;

    assign md_busy = (r_md_state == MD_BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_v      <= 1'b0;
            r_ex_wa     <= 5'd0;
            r_ex_ld     <= 1'b0;
            r_ex_rs     <= 5'd0;
            r_ex_rt     <= 5'd0;
            r_ex_use_rs <= 1'b0;
            r_ex_use_rt <= 1'b0;
            r_mem_v     <= 1'b0;
            r_mem_wa    <= 5'd0;
            r_mem_ld    <= 1'b0;
            r_wb_v      <= 1'b0;
            r_wb_wa     <= 5'd0;
        end else begin
            if (w_stall) begin
                r_ex_v      <= 1'b0;
                r_ex_wa     <= 5'd0;
                r_ex_ld     <= 1'b0;
                r_ex_rs     <= 5'd0;
                r_ex_rt     <= 5'd0;
                r_ex_use_rs <= 1'b0;
                r_ex_use_rt <= 1'b0;
            end else begin
                r_ex_v      <= w_id_v;
                r_ex_wa     <= id_waddr;
                r_ex_ld     <= id_load;
                r_ex_rs     <= id_rs;
                r_ex_rt     <= id_rt;
                r_ex_use_rs <= id_use_rs;
                r_ex_use_rt <= id_use_rt;
            end
            r_mem_v  <= r_ex_v;
            r_mem_wa <= r_ex_wa;
            r_mem_ld <= r_ex_ld;
            r_wb_v   <= r_mem_v;
            r_wb_wa  <= r_mem_wa;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_md_state <= MD_IDLE;
            r_md_cnt   <= 5'd0;
        end else begin
            r_md_state <= w_md_state_nxt;
            r_md_cnt   <= w_md_cnt_nxt;
        end
    end

    // Count is loaded with MD_LAT-1 and BUSY lasts through count==0, giving MD_LAT busy cycles.
    always_comb begin
        w_md_state_nxt = r_md_state;
        w_md_cnt_nxt   = r_md_cnt;
        case (r_md_state)
            MD_IDLE: begin
                if (id_md_start && !w_stall) begin
                    w_md_state_nxt = MD_BUSY;
                    w_md_cnt_nxt   = LP_MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (r_md_cnt == 5'd0)
                    w_md_state_nxt = MD_IDLE;
                else
                    w_md_cnt_nxt = r_md_cnt - 5'd1;
            end
            default: w_md_state_nxt = MD_IDLE;
        endcase
    end

endmodule
